// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer: one full-adder/subtractor cell,
// LSB first, registered carry/borrow, WIDTH+1 cycles per operation.
module serial_addsub_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] R,
    output logic             CO,
    output logic             OVF
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state;
    state_t nstate;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             mode_q;
    logic             c_q;
    logic [CW-1:0]    cnt;

    logic a_bit;
    logic b_bit;
    logic s_bit;
    logic c_nxt;
    logic ovf_nxt;
    logic last;
    logic accept;

    // One-bit add/sub cell; on the last bit a_bit/b_bit are the operand MSBs
    always_comb begin
        a_bit   = a_sh[0];
        b_bit   = b_sh[0];
        s_bit   = a_bit ^ b_bit ^ c_q;
        last    = (cnt == LAST);
        if (mode_q) begin
            c_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & c_q);
            ovf_nxt = (a_bit != b_bit) && (s_bit != a_bit);
        end else begin
            c_nxt   = (a_bit & b_bit) | (a_bit & c_q) | (b_bit & c_q);
            ovf_nxt = (a_bit == b_bit) && (s_bit != a_bit);
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state and status outputs
    always_comb begin
        nstate = state;
        BUSY   = 1'b0;
        DONE   = 1'b0;
        accept = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) begin
                    accept = 1'b1;
                    nstate = RUN;
                end
            end
            RUN: begin
                BUSY = 1'b1;
                if (last) begin
                    nstate = FIN;
                end
            end
            FIN: begin
                DONE = 1'b1;
                if (START) begin
                    accept = 1'b1;
                    nstate = RUN;
                end else begin
                    nstate = IDLE;
                end
            end
            default: begin
                nstate = IDLE;
            end
        endcase
    end

    // Operand latch, bit-serial shifting and result commit
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            mode_q <= 1'b0;
            c_q    <= 1'b0;
            cnt    <= '0;
            R      <= '0;
            CO     <= 1'b0;
            OVF    <= 1'b0;
        end else if (accept) begin
            a_sh   <= A;
            b_sh   <= B;
            r_sh   <= '0;
            mode_q <= MODE;
            c_q    <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= {s_bit, r_sh[WIDTH-1:1]};
            c_q  <= c_nxt;
            cnt  <= cnt + 1'b1;
            if (last) begin
                R   <= {s_bit, r_sh[WIDTH-1:1]};
                CO  <= c_nxt;
                OVF <= ovf_nxt;
            end
        end
    end

endmodule
